// File: rtl/wishbone_bus_mux_pkg.sv
// rtl/wishbone_bus_mux_pkg.sv - shared types and width helpers for the wishbone bus mux
package wishbone_bus_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ERR
    } mux_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A one-entry index still needs a one-bit register.
    function automatic int sel_width(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

endpackage

// File: rtl/wishbone_bus_mux_if.sv
// rtl/wishbone_bus_mux_if.sv - master side and slave fan-out signals of the wishbone bus mux
interface wishbone_bus_mux_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]            adr_o_master;
    logic [DATA_WIDTH-1:0]            dat_o_master;
    logic                             we_o_master;
    logic                             cyc_o_master;
    logic                             stb_o_master;
    logic [DATA_WIDTH-1:0]            dat_i_master;
    logic                             ack_i_master;
    logic                             err_i_master;

    logic [NUM_SLAVES*ADDR_WIDTH-1:0] adr_o_out;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] dat_o_out;
    logic [NUM_SLAVES-1:0]            we_o_out;
    logic [NUM_SLAVES-1:0]            cyc_o_out;
    logic [NUM_SLAVES-1:0]            stb_o_out;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] dat_i_in;
    logic [NUM_SLAVES-1:0]            ack_i_in;

    modport master (
        output adr_o_master, dat_o_master, we_o_master, cyc_o_master, stb_o_master,
        input  dat_i_master, ack_i_master, err_i_master
    );

    modport slave (
        input  adr_o_out, dat_o_out, we_o_out, cyc_o_out, stb_o_out,
        output dat_i_in, ack_i_in
    );

    modport mux (
        input  adr_o_master, dat_o_master, we_o_master, cyc_o_master, stb_o_master,
        output dat_i_master, ack_i_master, err_i_master,
        output adr_o_out, dat_o_out, we_o_out, cyc_o_out, stb_o_out,
        input  dat_i_in, ack_i_in
    );

endinterface

// File: rtl/wishbone_bus_mux_addr_decoder.sv
// rtl/wishbone_bus_mux_addr_decoder.sv - combinational window decode of the master address
module wishbone_addr_decoder
    import wishbone_bus_mux_pkg::*;
#(
    parameter int                    NUM_SLAVES = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    SPAN_LOG2  = 3,
    parameter int                    SEL_W      = sel_width(NUM_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0] adr,
    output logic [SEL_W-1:0]      index,
    output logic                  unmapped
);

    logic [ADDR_WIDTH:0] offset;
    logic [ADDR_WIDTH:0] limit;

    // The extra top bit catches addresses below the base instead of wrapping them.
    assign offset   = {1'b0, adr} - {1'b0, BASE_ADDR};
    assign limit    = (ADDR_WIDTH+1)'(NUM_SLAVES) << SPAN_LOG2;
    assign unmapped = offset[ADDR_WIDTH] | (offset >= limit);
    assign index    = offset[SPAN_LOG2 +: SEL_W];

endmodule

// File: rtl/wishbone_bus_mux.sv
// rtl/wishbone_bus_mux.sv - one-to-N wishbone interconnect; WB_BUS_MUX_TIMEOUT_EN adds a slave ack timeout
module wishbone_bus_mux
    import wishbone_bus_mux_pkg::*;
#(
    parameter int                    NUM_SLAVES     = 4,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    SPAN_LOG2      = 3,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    wishbone_bus_mux_if.mux bus
);

    localparam int SEL_W = sel_width(NUM_SLAVES);

    mux_state_e            state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [SEL_W-1:0]      dec_index;
    logic                  dec_unmapped;
    logic                  sel_ack;
    logic                  tmo_hit;
    logic [DATA_WIDTH-1:0] slave_rdata [NUM_SLAVES];

    wishbone_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .SPAN_LOG2  (SPAN_LOG2),
        .SEL_W      (SEL_W)
    ) u_decoder (
        .adr      (bus.adr_o_master),
        .index    (dec_index),
        .unmapped (dec_unmapped)
    );

    assign bus.adr_o_out = {NUM_SLAVES{bus.adr_o_master}};
    assign bus.dat_o_out = {NUM_SLAVES{bus.dat_o_master}};
    assign bus.we_o_out  = {NUM_SLAVES{bus.we_o_master}};

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_rdata
        assign slave_rdata[i] = bus.dat_i_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign sel_ack = bus.ack_i_in[sel_q];

`ifdef WB_BUS_MUX_TIMEOUT_EN
    localparam int CNT_W = sel_width(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Held at zero outside BUSY so every transfer starts its wait budget fresh.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q != ST_BUSY) begin
            tmo_cnt_q <= '0;
        end else if (!sel_ack) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        sel_d            = sel_q;
        bus.cyc_o_out    = '0;
        bus.stb_o_out    = '0;
        bus.ack_i_master = 1'b0;
        bus.err_i_master = 1'b0;
        bus.dat_i_master = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cyc_o_master && bus.stb_o_master) begin
                    if (dec_unmapped) begin
                        state_d = ST_ERR;
                    end else begin
                        sel_d   = dec_index;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                bus.cyc_o_out[sel_q] = bus.cyc_o_master;
                bus.stb_o_out[sel_q] = bus.stb_o_master;
                bus.ack_i_master     = sel_ack;
                bus.dat_i_master     = slave_rdata[sel_q];
                // A completing ack takes priority over a timeout in the same cycle.
                if (sel_ack || !bus.cyc_o_master) begin
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                bus.err_i_master = 1'b1;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_bus_mux.sv
// tb/tb_wishbone_bus_mux.sv - randomized self-checking bench for wishbone_bus_mux
module tb_wishbone_bus_mux;

    localparam int          NS   = 4;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h100;
    localparam int          SPAN = 4;
    localparam int          TMO  = 5;
`ifdef WB_BUS_MUX_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  force_ack = '0;
    int          lat_q [NS];
    int          wcnt [NS];
    logic [31:0] slave_data [NS];
    int          n_checks = 0;
    int          n_fail = 0;

    wishbone_bus_mux_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wishbone_bus_mux #(
        .NUM_SLAVES     (NS),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .BASE_ADDR      (BASE),
        .SPAN_LOG2      (SPAN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Slave models: ack once the strobe has been held for lat_q wait states.
    always_comb begin
        bus.ack_i_in = force_ack;
        bus.dat_i_in = '0;
        for (int i = 0; i < NS; i++) begin
            if (bus.stb_o_out[i] && bus.cyc_o_out[i] && (wcnt[i] >= lat_q[i])) bus.ack_i_in[i] = 1'b1;
            bus.dat_i_in[i*DW +: DW] = slave_data[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (bus.stb_o_out[i] && !bus.ack_i_in[i]) wcnt[i] <= wcnt[i] + 1;
            else wcnt[i] <= 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stb"}, 64'(bus.stb_o_out), 64'h0);
        check({tag, "_cyc"}, 64'(bus.cyc_o_out), 64'h0);
        check({tag, "_ack"}, 64'(bus.ack_i_master), 64'h0);
        check({tag, "_err"}, 64'(bus.err_i_master), 64'h0);
        check({tag, "_dat"}, 64'(bus.dat_i_master), 64'h0);
    endtask

    // Caller is positioned just after a rising edge; returns just after the edge ending the response.
    task automatic run_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int lat, input logic [3:0] stray);
        bit   mapped, exp_err, got, got_err;
        int   idx, exp_cyc, got_cyc;
        logic [31:0] off, exp_stb, got_dat;
        mapped = 1'b0;
        idx = 0;
        if (addr >= BASE) begin
            off = addr - BASE;
            idx = int'(off >> SPAN);
            mapped = (off >> SPAN) < NS;
        end
        if (!mapped) begin
            exp_err = 1'b1; exp_cyc = 1;
        end else if (TMO_EN && lat > TMO) begin
            exp_err = 1'b1; exp_cyc = TMO + 2;
        end else begin
            exp_err = 1'b0; exp_cyc = 1 + lat;
        end
        if (mapped) begin
            lat_q[idx] = lat;
            slave_data[idx] = rdata;
            stray = stray & ~(4'b1 << idx);
        end
        force_ack = stray;
        bus.adr_o_master = addr;
        bus.dat_o_master = wdata;
        bus.we_o_master  = we;
        bus.cyc_o_master = 1'b1;
        bus.stb_o_master = 1'b1;
        got = 1'b0; got_err = 1'b0; got_cyc = -1; got_dat = '0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            exp_stb = (mapped && k >= 1 && (k < exp_cyc || (k == exp_cyc && !exp_err))) ? (32'h1 << idx) : 32'h0;
            check("stb_route", 64'(bus.stb_o_out), 64'(exp_stb));
            check("ack_err_excl", 64'(bus.ack_i_master & bus.err_i_master), 64'h0);
            if (bus.ack_i_master || bus.err_i_master) begin
                got = 1'b1; got_err = bus.err_i_master; got_cyc = k; got_dat = bus.dat_i_master;
                if (bus.ack_i_master) begin
                    check("wr_dat", 64'(bus.dat_o_out[idx*DW +: DW]), 64'(wdata));
                    check("wr_adr", 64'(bus.adr_o_out[idx*AW +: AW]), 64'(addr));
                    check("wr_we", 64'(bus.we_o_out[idx]), 64'(we));
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        check("resp_seen", 64'(got), 64'h1);
        check("resp_cycle", 64'(got_cyc), 64'(exp_cyc));
        check("resp_is_err", 64'(got_err), 64'(exp_err));
        if (got && !got_err && !we) check("rd_data", 64'(got_dat), 64'(rdata));
        @(posedge clk); #1;
        bus.cyc_o_master = 1'b0;
        bus.stb_o_master = 1'b0;
        force_ack = '0;
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < NS; i++) begin
            lat_q[i] = 0; wcnt[i] = 0; slave_data[i] = '0;
        end
        bus.adr_o_master = '0; bus.dat_o_master = '0; bus.we_o_master = 1'b0;
        bus.cyc_o_master = 1'b0; bus.stb_o_master = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_xfer(32'h125, 1'b0, 32'h0, 32'hCAFEF00D, 0, 4'h0);
        run_xfer(32'h0FF, 1'b0, 32'h0, 32'h0, 0, 4'h0);
        run_xfer(32'h140, 1'b1, 32'h1234, 32'h0, 0, 4'h0);
        run_xfer(32'h100, 1'b0, 32'h0, 32'h11112222, 1, 4'h0);
        run_xfer(32'h13F, 1'b1, 32'hA5A5A5A5, 32'h0, 2, 4'h0);
        run_xfer(32'h120, 1'b0, 32'h0, 32'h5555AAAA, 3, 4'h1);

        force_ack = 4'hF;
        #1 check("stray_idle_ack", 64'(bus.ack_i_master), 64'h0);
        force_ack = '0;

        // Abort: slave 1 stalls, master drops cyc in the fourth cycle.
        lat_q[1] = 15;
        bus.adr_o_master = 32'h118; bus.we_o_master = 1'b0;
        bus.cyc_o_master = 1'b1; bus.stb_o_master = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("abort_pre_stb", 64'(bus.stb_o_out), 64'h2);
        @(posedge clk); #1;
        bus.cyc_o_master = 1'b0; bus.stb_o_master = 1'b0;
        #1 check_quiet("abort_drop");
        @(posedge clk); #1;
        run_xfer(32'h118, 1'b0, 32'h0, 32'h0BADBEEF, 0, 4'h0);

        // Reset asserted while slave 3 is being waited on.
        lat_q[3] = 10;
        bus.adr_o_master = 32'h130;
        bus.cyc_o_master = 1'b1; bus.stb_o_master = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("pre_reset_stb", 64'(bus.stb_o_out), 64'h8);
        #2 rst_n = 1'b0;
        #1 check_quiet("async_reset");
        bus.cyc_o_master = 1'b0; bus.stb_o_master = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_xfer(32'h131, 1'b0, 32'h0, 32'h600DF00D, 0, 4'h0);

        // Long stall: timeout build errors out, default build keeps waiting.
        run_xfer(32'h13C, 1'b0, 32'h0, 32'h77778888, TMO_EN ? 40 : 30, 4'h0);
        run_xfer(32'h13C, 1'b0, 32'h0, 32'h9999AAAA, TMO, 4'h0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom_range(32'h160, 32'h0C0);
            run_xfer(a, 1'($urandom_range(1, 0)), $urandom, $urandom,
                     $urandom_range(3, 0), 4'($urandom_range(15, 0)));
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
